// File: rtl/uio_xor_sequencer_if.sv
// Bus interface for uio_xor_sequencer.
// Carries every non-clock/reset signal of the sequencer:
//   ena, start, abort      - control from user logic (master -> slave)
//   op_a, uio_in           - operand A (ui_in) and uio pad input (master -> slave)
//   uio_out, uio_oe        - uio pad output value and output enable (slave -> master)
//   result                 - last computed A^B (slave -> master)
//   busy, done, aborted    - status and one-cycle event pulses (slave -> master)
//   txn_count              - completed transaction counter (slave -> master)
interface uio_xor_sequencer_if;
  logic       ena;
  logic       start;
  logic       abort;
  logic [7:0] op_a;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] result;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [7:0] txn_count;

  modport master (
    output ena, start, abort, op_a, uio_in,
    input  uio_out, uio_oe, result, busy, done, aborted, txn_count
  );

  modport slave (
    input  ena, start, abort, op_a, uio_in,
    output uio_out, uio_oe, result, busy, done, aborted, txn_count
  );
endinterface

// File: rtl/uio_xor_sequencer.sv
// uio_xor_sequencer: time-shares the bidirectional uio pins of the ui/uio XOR datapath.
// A transaction captures op_a, samples uio_in one cycle later, computes A^B, idles the
// pins for a turnaround gap, drives A^B for DRIVE_CYCLES, then idles again before release.
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset
//   bus    - slave modport of uio_xor_sequencer_if (controls, operands, pad and status outputs)
// uio_oe/uio_out are decoded purely from registered state and result.
module uio_xor_sequencer #(
  parameter int unsigned DRIVE_CYCLES = 4,    // 1..255
  parameter int unsigned TURN_CYCLES  = 1,    // 1..15
  parameter logic [7:0]  OE_MASK      = 8'hFF
) (
  input logic                    clk,
  input logic                    rst_n,
  uio_xor_sequencer_if.slave     bus
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSample  = 3'd1,
    StTurnIn  = 3'd2,
    StDrive   = 3'd3,
    StTurnOut = 3'd4
  } state_e;

  // Counter holds remaining cycles minus one, so 0 means "last cycle of this phase".
  localparam logic [7:0] DriveLoad = 8'(DRIVE_CYCLES - 1);
  localparam logic [7:0] TurnLoad  = 8'(TURN_CYCLES - 1);

  state_e     r_state,       w_state_next;
  logic [7:0] r_cnt,         w_cnt_next;
  logic [7:0] r_a,           w_a_next;
  logic [7:0] r_result,      w_result_next;
  logic       r_done,        w_done_next;
  logic       r_aborted,     w_aborted_next;
  logic [7:0] r_txn_count,   w_txn_count_next;
  // Set when DRIVE was cut short; suppresses done/count on the TURN_OUT exit.
  logic       r_abort_seen,  w_abort_seen_next;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= 8'd0;
      r_a          <= 8'd0;
      r_result     <= 8'd0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_txn_count  <= 8'd0;
      r_abort_seen <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_a          <= w_a_next;
      r_result     <= w_result_next;
      r_done       <= w_done_next;
      r_aborted    <= w_aborted_next;
      r_txn_count  <= w_txn_count_next;
      r_abort_seen <= w_abort_seen_next;
    end
  end

  // Next-state logic; ena=0 holds every register, pulses included.
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_a_next          = r_a;
    w_result_next     = r_result;
    w_done_next       = r_done;
    w_aborted_next    = r_aborted;
    w_txn_count_next  = r_txn_count;
    w_abort_seen_next = r_abort_seen;

    if (bus.ena) begin
      w_done_next    = 1'b0;
      w_aborted_next = 1'b0;
      case (r_state)
        StIdle: begin
          // abort wins over a simultaneous start; nothing to cancel so no pulse
          if (bus.start && !bus.abort) begin
            w_a_next          = bus.op_a;
            w_abort_seen_next = 1'b0;
            w_state_next      = StSample;
          end
        end
        StSample: begin
          // result updates even if this cycle is aborted
          w_result_next = r_a ^ bus.uio_in;
          if (bus.abort) begin
            w_aborted_next = 1'b1;
            w_state_next   = StIdle;
          end else begin
            w_cnt_next   = TurnLoad;
            w_state_next = StTurnIn;
          end
        end
        StTurnIn: begin
          if (bus.abort) begin
            w_aborted_next = 1'b1;
            w_state_next   = StIdle;
          end else if (r_cnt == 8'd0) begin
            w_cnt_next   = DriveLoad;
            w_state_next = StDrive;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        StDrive: begin
          if (bus.abort) begin
            // release pins through a full turnaround rather than dropping to IDLE
            w_aborted_next    = 1'b1;
            w_abort_seen_next = 1'b1;
            w_cnt_next        = TurnLoad;
            w_state_next      = StTurnOut;
          end else if (r_cnt == 8'd0) begin
            w_cnt_next   = TurnLoad;
            w_state_next = StTurnOut;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        StTurnOut: begin
          if (r_cnt == 8'd0) begin
            w_state_next = StIdle;
            if (!r_abort_seen) begin
              w_done_next      = 1'b1;
              w_txn_count_next = r_txn_count + 8'd1;
            end
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
        default: begin
          w_state_next = StIdle;
        end
      endcase
    end
  end

  // Output decode from registers only
  always_comb begin
    bus.uio_oe  = 8'h00;
    bus.uio_out = 8'h00;
    if (r_state == StDrive) begin
      bus.uio_oe  = OE_MASK;
      bus.uio_out = r_result & OE_MASK;
    end
  end

  assign bus.result    = r_result;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;
  assign bus.aborted   = r_aborted;
  assign bus.txn_count = r_txn_count;

endmodule

// File: tb/tb_uio_xor_sequencer.sv
// Directed testbench for uio_xor_sequencer: default instance plus an OE_MASK=8'h0F instance.
module tb_uio_xor_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  uio_xor_sequencer_if if0 ();
  uio_xor_sequencer_if if1 ();

  uio_xor_sequencer dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  uio_xor_sequencer #(
    .OE_MASK (8'h0F)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int dones;
    int drv;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    if0.ena = 1'b1; if0.start = 1'b0; if0.abort = 1'b0; if0.op_a = 8'h00; if0.uio_in = 8'h00;
    if1.ena = 1'b1; if1.start = 1'b0; if1.abort = 1'b0; if1.op_a = 8'h00; if1.uio_in = 8'h00;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_oe", if0.uio_oe, 8'h00);
    chk("rst_out", if0.uio_out, 8'h00);
    chk("rst_result", if0.result, 8'h00);
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_done", if0.done, 1'b0);
    chk("rst_aborted", if0.aborted, 1'b0);
    chk("rst_txn", if0.txn_count, 8'h00);
    rst_n = 1'b1;

    // Basic transaction on dut0, masked transaction on dut1 in lockstep
    if0.start = 1'b1; if0.op_a = 8'hA5; if0.uio_in = 8'h3C;
    if1.start = 1'b1; if1.op_a = 8'hFF; if1.uio_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if0.start = 1'b0;
        if1.start = 1'b0;
      end
      chk($sformatf("t1_oe_c%0d", i), if0.uio_oe, (i >= 2 && i <= 5) ? 8'hFF : 8'h00);
      chk($sformatf("t1_out_c%0d", i), if0.uio_out, (i >= 2 && i <= 5) ? 8'h99 : 8'h00);
      chk($sformatf("t1_done_c%0d", i), if0.done, (i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("t2_oe_c%0d", i), if1.uio_oe, (i >= 2 && i <= 5) ? 8'h0F : 8'h00);
      chk($sformatf("t2_out_c%0d", i), if1.uio_out, (i >= 2 && i <= 5) ? 8'h0F : 8'h00);
    end
    chk("t1_result", if0.result, 8'h99);
    chk("t1_txn", if0.txn_count, 8'd1);
    chk("t1_busy", if0.busy, 1'b0);
    chk("t2_txn", if1.txn_count, 8'd1);
    @(negedge clk);
    chk("t1_done_clear", if0.done, 1'b0);

    // start and abort together in IDLE: abort wins, nothing happens
    if0.start = 1'b1; if0.abort = 1'b1;
    @(negedge clk);
    if0.start = 1'b0; if0.abort = 1'b0;
    chk("sa_busy", if0.busy, 1'b0);
    chk("sa_aborted", if0.aborted, 1'b0);

    // Abort on the second DRIVE cycle
    if0.start = 1'b1; if0.op_a = 8'h12; if0.uio_in = 8'h34;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) if0.start = 1'b0;
    end
    chk("t3_drive2_oe", if0.uio_oe, 8'hFF);
    if0.abort = 1'b1;
    @(negedge clk);
    if0.abort = 1'b0;
    chk("t3_oe_released", if0.uio_oe, 8'h00);
    chk("t3_aborted", if0.aborted, 1'b1);
    chk("t3_busy_turnout", if0.busy, 1'b1);
    chk("t3_result", if0.result, 8'h26);
    @(negedge clk);
    chk("t3_idle", if0.busy, 1'b0);
    chk("t3_aborted_clear", if0.aborted, 1'b0);
    chk("t3_no_done", if0.done, 1'b0);
    chk("t3_txn", if0.txn_count, 8'd1);
    @(negedge clk);
    chk("t3_no_done_late", if0.done, 1'b0);

    // Fresh reset, then start held for three back-to-back transactions
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_rst_txn", if0.txn_count, 8'd0);
    if0.start = 1'b1; if0.op_a = 8'h0F; if0.uio_in = 8'hF0;
    dones = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (if0.done) begin
        dones++;
        chk("t4_done_pos", i % 8, 7);
      end
    end
    if0.start = 1'b0;
    chk("t4_dones", dones, 3);
    chk("t4_txn", if0.txn_count, 8'd3);
    chk("t4_result", if0.result, 8'hFF);
    @(negedge clk);
    chk("t4_idle", if0.busy, 1'b0);

    // ena=0 for 5 cycles in the middle of DRIVE
    if0.start = 1'b1; if0.op_a = 8'h5A; if0.uio_in = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) if0.start = 1'b0;
    end
    chk("t5_drive2_oe", if0.uio_oe, 8'hFF);
    if0.ena = 1'b0;
    if0.start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t5_hold_oe_%0d", k), if0.uio_oe, 8'hFF);
      chk($sformatf("t5_hold_out_%0d", k), if0.uio_out, 8'h55);
    end
    if0.start = 1'b0;
    if0.ena = 1'b1;
    drv = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (if0.uio_oe == 8'hFF) drv++;
    end
    chk("t5_remaining_drive", drv, 2);
    chk("t5_done", if0.done, 1'b1);
    chk("t5_txn", if0.txn_count, 8'd4);
    // done is held, not stretched, while ena=0
    if0.ena = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_done_frozen", if0.done, 1'b1);
    if0.ena = 1'b1;
    @(negedge clk);
    chk("t5_done_clear", if0.done, 1'b0);

    // Asynchronous reset mid-DRIVE
    if0.start = 1'b1; if0.op_a = 8'hC3; if0.uio_in = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) if0.start = 1'b0;
    end
    chk("t6_drive_oe", if0.uio_oe, 8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_oe", if0.uio_oe, 8'h00);
    chk("t6_async_out", if0.uio_out, 8'h00);
    chk("t6_async_busy", if0.busy, 1'b0);
    chk("t6_async_result", if0.result, 8'h00);
    chk("t6_async_txn", if0.txn_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // 256 transactions: counter wraps to 0
    if0.start = 1'b1; if0.op_a = 8'h01; if0.uio_in = 8'h00;
    dones = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (if0.done) dones++;
      if (i == 2039) chk("wrap_txn_255", if0.txn_count, 8'hFF);
    end
    if0.start = 1'b0;
    chk("wrap_dones", dones, 256);
    chk("wrap_txn_0", if0.txn_count, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
